muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the five-stage MIPS pipeline. It runs in parallel with the ALU in EX. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, computes multiply and divide over 32 radix-2 iterations plus one sign-fix cycle, and holds HI/LO. HI and LO feed the writeback result-select 4:1 mux (data2 = HI, data3 = LO) for MFHI/MFLO.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  issue request from EX, qualified by op.
- op  in  3  3'b000 MULT, 3'b001 MULTU, 3'b010 DIV, 3'b011 DIVU, 3'b100 MTHI, 3'b101 MTLO; other values are ignored.
- flush  in  1  abort the in-flight operation; HI/LO are unchanged.
- a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- b  in  32  rt operand (divisor / multiplier).
- busy  out  1  operation in flight; the hazard unit stalls MFHI/MFLO and new muldiv ops while this is high.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE → RUN on start with op in 000–011.
  - Latch |a| and |b| (or raw values for the unsigned ops).
  - Latch the result sign: for signed multiply and quotient, a[31]^b[31]; for remainder, a[31].
  - Clear the iteration counter (6 bits) and the accumulator.
- RUN: one iteration per cycle; counter increments; RUN → FIX when the counter reaches 31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring; remainder shifts left, subtract-compare, quotient bit shifts in.
- FIX: conditionally two's-complement the 64-bit product, or the quotient and remainder separately.
  - Write {HI,LO} (multiply) or HI = remainder, LO = quotient (divide).
  - Pulse done; go to IDLE.
- MTHI/MTLO with start in IDLE: write hi (or lo) from a on that edge. Takes one cycle; busy and done stay low.
- start while busy=1 is ignored. The hazard unit must not issue it, but the unit is robust to it.
- Divide by zero (b == 0, signed or unsigned): HI = a, LO = 32'hFFFFFFFF, produced on the normal 33-cycle schedule.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the magnitude path with no special case.
- flush in RUN/FIX: return to IDLE next edge; no done; HI/LO keep their pre-op values.
  - flush with a simultaneous start in IDLE: flush wins and the op is not accepted.
- Arithmetic: the product is 64-bit and never truncated before the HI/LO split. The divide subtractor is 33-bit to capture the borrow.

## Timing
- Reset: state IDLE, busy 0, done 0, hi 0, lo 0, counter 0. Reset asserted mid-operation aborts immediately and asynchronously to these values.
- Start accepted at edge E0:
  - busy = 1 from after E0 through E33.
  - RUN covers E1–E32; FIX is the state after E32.
  - HI/LO are written at E33. done = 1 for the cycle after E33, and busy = 0 in that same cycle.
- Total latency is 33 cycles, fixed regardless of operand values. There is no early termination.
- Back-to-back: a new start is accepted in the cycle done is high (edge E34).
- MTHI/MTLO: the new value is visible the cycle after the accepting edge.

## Structure
- Shared package `muldiv_pkg`:
  - Op encodings (OP_MULT … OP_MTLO).
  - State encodings (ST_IDLE, ST_RUN, ST_FIX).
  - ITER_LAST = 31.
- One sub-module, `div_step`: combinational restoring-divide step.
  - Inputs: remainder, divisor, dividend bit.
  - Outputs: next remainder, quotient bit.
  - Instantiated once in the datapath.
- Everything else is in `muldiv_unit`.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002 → after 33 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFE; busy high exactly 33 cycles.
- MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 → LO=14, HI=2.
- DIVU a=5, b=0 → LO=0xFFFFFFFF, HI=5. DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI a=0x12345678 → hi=0x12345678 next cycle, busy/done never assert. Then MULT, with flush at cycle 10 → busy drops next cycle, no done, hi still 0x12345678.
- Assert rst mid-DIV at cycle 5 → busy, done, hi, lo read 0 immediately. A start issued while busy is ignored: only one done pulse, carrying the first op's result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg
// Shared op/state encodings and helpers for the iterative multiply/divide unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [5:0] ITER_LAST = 6'd31;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_div_step.sv
// ============================================================================
// div_step
// One combinational restoring-divide step: shift in a dividend bit, trial
// subtract, restore on borrow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             quo_bit
);

    logic [WIDTH-1:0] shifted_low;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    assign shifted_low = {rem_in[WIDTH-2:0], dividend_bit};

    // The shifted remainder is WIDTH+1 bits; its MSB being set means it
    // already exceeds any WIDTH-bit divisor, so the subtract must succeed.
    assign {borrow, diff} = {1'b0, shifted_low} - {1'b0, divisor};

    assign quo_bit = rem_in[WIDTH-1] | ~borrow;
    assign rem_out = quo_bit ? diff : shifted_low;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
// Iterative 32-cycle multiply/divide with sign-fix cycle and HI/LO registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t               state;
    state_t               state_nxt;
    logic [5:0]           cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;

    logic                 idle_req;
    logic                 accept;
    logic                 mt_write;
    logic                 op_signed;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_nxt;
    logic [WIDTH-1:0]     rem_nxt;
    logic                 quo_bit;
    logic [2*WIDTH-1:0]   acc_neg;
    logic [WIDTH-1:0]     rem_neg;
    logic [WIDTH-1:0]     quo_neg;

    assign idle_req  = start & ~flush & (state == ST_IDLE);
    assign accept    = idle_req & ~op[2];
    assign mt_write  = idle_req & ((op == OP_MTHI) | (op == OP_MTLO));
    assign op_signed = ~op[0];
    assign a_mag     = op_signed ? abs32(a) : a;
    assign b_mag     = op_signed ? abs32(b) : b;

    // Multiply: low half of acc holds the remaining multiplier bits.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts the
    // dividend out and the quotient in.
    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (acc[2*WIDTH-1:WIDTH]),
        .divisor      (opnd),
        .dividend_bit (acc[WIDTH-1]),
        .rem_out      (rem_nxt),
        .quo_bit      (quo_bit)
    );

    assign acc_neg = ~acc + {{(2*WIDTH-1){1'b0}}, 1'b1};
    assign rem_neg = ~acc[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1};
    assign quo_neg = ~acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)                state_nxt = ST_RUN;
            ST_RUN:  if (flush)                 state_nxt = ST_IDLE;
                     else if (cnt == ITER_LAST) state_nxt = ST_FIX;
            ST_FIX:                             state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 6'd0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt     <= 6'd0;
                        is_div  <= op[1];
                        neg_rem <= op_signed & op[1] & a[WIDTH-1];
                        // A zero divisor leaves the all-ones quotient unsigned.
                        neg_res <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1])
                                   & ~(op[1] & (b == '0));
                        if (op[1]) begin
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                            opnd <= b_mag;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end
                    end else if (mt_write) begin
                        if (op == OP_MTHI) hi <= a;
                        else               lo <= a;
                    end
                end
                ST_RUN: begin
                    if (!flush) begin
                        cnt <= cnt + 6'd1;
                        acc <= is_div ? {rem_nxt, acc[WIDTH-2:0], quo_bit} : mul_nxt;
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= neg_rem ? rem_neg : acc[2*WIDTH-1:WIDTH];
                            lo <= neg_res ? quo_neg : acc[WIDTH-1:0];
                        end else begin
                            {hi, lo} <= neg_res ? acc_neg : acc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit
// Self-checking bench: vector table with scoreboard plus multi-cycle sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .flush (flush),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Called at a negedge; drives one op and waits for its done pulse.
    task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eh, input logic [31:0] el, input int idx);
        int   busy_cnt;
        exp_t e;
        start = 1'b1; op = o; a = va; b = vb;
        e.hi = eh; e.lo = el;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        busy_cnt = 0;
        @(negedge clk);
        while (busy && busy_cnt < 100) begin
            busy_cnt++;
            @(negedge clk);
        end
        check($sformatf("vec%0d busy_cycles", idx), busy_cnt, 32'd33);
        check($sformatf("vec%0d done", idx), {31'd0, done}, 32'd1);
        e = sb.pop_front();
        check($sformatf("vec%0d hi", idx), hi, e.hi);
        check($sformatf("vec%0d lo", idx), lo, e.lo);
    endtask

    initial begin
        int dones;
        exp_t e;
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4] = '{3'b011, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[5] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6] = '{3'b010, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7] = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[8] = '{3'b000, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'd15};
        vecs[9] = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        // MTHI / MTLO: single-cycle writes, no busy or done.
        start = 1'b1; op = 3'b100; a = 32'h12345678;
        @(posedge clk);
        #1 start = 1'b0;
        check("mthi busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("mthi hi", hi, 32'h12345678);
        check("mthi done", {31'd0, done}, 32'd0);
        start = 1'b1; op = 3'b101; a = 32'hCAFEF00D;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("mtlo lo", lo, 32'hCAFEF00D);
        check("mtlo hi kept", hi, 32'h12345678);

        // Flush mid-multiply.
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush pre busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush busy", {31'd0, busy}, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("flush no done", dones, 32'd0);
        check("flush hi kept", hi, 32'h12345678);
        check("flush lo kept", lo, 32'hCAFEF00D);

        // Flush beats a simultaneous start.
        start = 1'b1; flush = 1'b1; op = 3'b000;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush+start busy", {31'd0, busy}, 32'd0);

        // Vector table; each op after the first starts in the done cycle.
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, i);

        // Start while busy must be ignored.
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
        e.hi = 32'd2; e.lo = 32'd14;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("ignored-start hi", hi, e.hi);
                    check("ignored-start lo", lo, e.lo);
                end
            end
        end
        check("ignored-start done count", dones, 32'd1);

        // Asynchronous reset mid-divide.
        start = 1'b1; op = 3'b010; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst done", {31'd0, done}, 32'd0);
        check("async rst hi", hi, 32'd0);
        check("async rst lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post-reset busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
